// File: rtl/leve_axi_pkg.sv
// Shared AXI read-channel encodings, FSM states and the beat record used by the
// LEVE instruction ROM target.
package leve_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_STREAM
  } rdState_e;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rBeat_t;

endpackage

// File: rtl/leve_rdbuf2.sv
// Two-entry FIFO of R beats sitting between the registered memory read and the
// R channel, so memory reads never wait combinationally on RREADY.
module leve_rdbuf2
  import leve_axi_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  rBeat_t pushBeat_i,
  input  logic   pop_i,
  output rBeat_t headBeat_o,
  output logic   valid_o,
  output logic   full_o
);

  rBeat_t     ent0_q, ent0_d;
  rBeat_t     ent1_q, ent1_d;
  logic [1:0] cnt_q, cnt_d;

  // Pop shifts first, so a push in the same cycle lands behind the surviving entry.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (pop_i && (cnt_q != 2'd0)) begin
      ent0_d = ent1_q;
      cnt_d  = cnt_q - 2'd1;
    end
    if (push_i && (cnt_d != 2'd2)) begin
      if (cnt_d == 2'd0) begin
        ent0_d = pushBeat_i;
      end else begin
        ent1_d = pushBeat_i;
      end
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign headBeat_o = ent0_q;
  assign valid_o    = (cnt_q != 2'd0);
  assign full_o     = (cnt_q == 2'd2);

endmodule

// File: rtl/leve_axir_rom_targ.sv
// Read-only AXI read-channel target serving instruction fetches from a word
// memory with programmable first-beat latency and a sideband preload port.
module leve_axir_rom_targ
  import leve_axi_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 4096,
  parameter logic [XLEN-1:0] BASE_ADDR = '0,
  parameter int unsigned     LATENCY   = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  input  logic [XLEN-1:0]          ARADDR,
  input  logic [7:0]               ARLEN,
  input  logic [1:0]               ARBURST,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic [31:0]              RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  input  logic                     LD_WE,
  input  logic [$clog2(DEPTH)-1:0] LD_ADDR,
  input  logic [31:0]              LD_DATA
);

  localparam int unsigned IDXW     = $clog2(DEPTH);
  localparam logic [3:0]  LAT_INIT = 4'(LATENCY - 1);

  rdState_e        state_q, state_d;
  logic            arReady_q;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [1:0]      burst_q, burst_d;
  logic [7:0]      issLeft_q, issLeft_d;
  logic [3:0]      latCnt_q, latCnt_d;
  logic            memVld_q, memVld_d;
  logic [31:0]     memData_q;
  logic [1:0]      memResp_q;
  logic            memLast_q;
  logic [31:0]     mem [DEPTH];

  logic            arHs, issueBurst, issue, push, pop, bufValid, bufFull;
  logic            issLast, inRange;
  logic [XLEN-1:0] issAddr, wordOff;
  logic [1:0]      issBurst, issResp;
  logic [IDXW-1:0] memIdx;
  rBeat_t          pushBeat, headBeat;

  // Beat 0 is read on the AR handshake itself; later beats are prefetched while
  // the buffer plus the read register still have room, independent of RREADY.
  assign arHs       = ARVALID && arReady_q;
  assign issueBurst = (state_q != ST_IDLE) && (issLeft_q != 8'd0) && (!memVld_q || !bufFull);
  assign issue      = arHs || issueBurst;
  assign issAddr    = arHs ? (ARADDR & ~XLEN'(3)) : addr_q;
  assign issBurst   = arHs ? ARBURST : burst_q;
  assign issLast    = arHs ? (ARLEN == 8'd0) : (issLeft_q == 8'd1);
  assign wordOff    = (issAddr - BASE_ADDR) >> 2;
  assign inRange    = (wordOff < XLEN'(DEPTH));
  assign memIdx     = wordOff[IDXW-1:0];

  always_comb begin
    issResp = RESP_OKAY;
    if (!((issBurst == BURST_FIXED) || (issBurst == BURST_INCR))) begin
      issResp = RESP_SLVERR;
    end else if (!inRange) begin
      issResp = RESP_DECERR;
    end
  end

  assign push     = memVld_q && !bufFull;
  assign pushBeat = '{data: (memResp_q == RESP_OKAY) ? memData_q : 32'h0,
                      resp: memResp_q,
                      last: memLast_q};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    burst_d   = burst_q;
    issLeft_d = issLeft_q;
    latCnt_d  = latCnt_q;
    memVld_d  = issue ? 1'b1 : (push ? 1'b0 : memVld_q);
    if (issue) begin
      addr_d = (issBurst == BURST_INCR) ? issAddr + XLEN'(4) : issAddr;
    end
    if (issueBurst) begin
      issLeft_d = issLeft_q - 8'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (arHs) begin
          state_d   = ST_WAIT;
          burst_d   = ARBURST;
          issLeft_d = ARLEN;
          latCnt_d  = LAT_INIT;
        end
      end
      ST_WAIT: begin
        if (latCnt_q == 4'd0) begin
          state_d = ST_STREAM;
        end else begin
          latCnt_d = latCnt_q - 4'd1;
        end
      end
      ST_STREAM: begin
        if (pop && headBeat.last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      arReady_q <= 1'b0;
      addr_q    <= '0;
      burst_q   <= BURST_FIXED;
      issLeft_q <= 8'd0;
      latCnt_q  <= 4'd0;
      memVld_q  <= 1'b0;
      memResp_q <= RESP_OKAY;
      memLast_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arReady_q <= (state_d == ST_IDLE);
      addr_q    <= addr_d;
      burst_q   <= burst_d;
      issLeft_q <= issLeft_d;
      latCnt_q  <= latCnt_d;
      memVld_q  <= memVld_d;
      if (issue) begin
        memResp_q <= issResp;
        memLast_q <= issLast;
      end
    end
  end

  // Array has no reset so the preloaded image survives RST; read-first on collisions.
  always_ff @(posedge CLK) begin
    if (LD_WE) begin
      mem[LD_ADDR] <= LD_DATA;
    end
    if (issue) begin
      memData_q <= mem[memIdx];
    end
  end

  leve_rdbuf2 u_rdbuf (
    .clk_i      (CLK),
    .rst_i      (RST),
    .push_i     (push),
    .pushBeat_i (pushBeat),
    .pop_i      (pop),
    .headBeat_o (headBeat),
    .valid_o    (bufValid),
    .full_o     (bufFull)
  );

  assign ARREADY = arReady_q;
  assign RVALID  = (state_q == ST_STREAM) && bufValid;
  assign pop     = RVALID && RREADY;
  assign RDATA   = RVALID ? headBeat.data : 32'h0;
  assign RRESP   = RVALID ? headBeat.resp : RESP_OKAY;
  assign RLAST   = RVALID && headBeat.last;

endmodule

// File: tb/tb_leve_axir_rom_targ.sv
// Self-checking bench for leve_axir_rom_targ: vector table of AR requests with
// expected beats fed to a scoreboard, plus latency, throughput and reset cases.
module tb_leve_axir_rom_targ;
  import leve_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arValid = 1'b0;
  logic        arReady;
  logic [31:0] arAddr = 32'h0;
  logic [7:0]  arLen = 8'd0;
  logic [1:0]  arBurst = 2'b00;
  logic        rValid;
  logic        rReady = 1'b1;
  logic [31:0] rData;
  logic [1:0]  rResp;
  logic        rLast;
  logic        ldWe = 1'b0;
  logic [11:0] ldAddr = 12'd0;
  logic [31:0] ldData = 32'h0;

  int checks = 0;
  int errors = 0;
  int hsCount = 0;
  int rrMode = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0]       addr;
    logic [7:0]        len;
    logic [1:0]        burst;
    logic [0:3][31:0]  expData;
    logic [0:3][1:0]   expResp;
  } vec_t;

  beat_t sb[$];
  vec_t  vecs[9];

  always #5 clk = ~clk;

  leve_axir_rom_targ #(
    .XLEN      (32),
    .DEPTH     (4096),
    .BASE_ADDR (32'h0),
    .LATENCY   (1)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .ARVALID (arValid),
    .ARREADY (arReady),
    .ARADDR  (arAddr),
    .ARLEN   (arLen),
    .ARBURST (arBurst),
    .RVALID  (rValid),
    .RREADY  (rReady),
    .RDATA   (rData),
    .RRESP   (rResp),
    .RLAST   (rLast),
    .LD_WE   (ldWe),
    .LD_ADDR (ldAddr),
    .LD_DATA (ldData)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expectBeat(input logic [31:0] data, input logic [1:0] resp, input logic last);
    beat_t e;
    e.data = data;
    e.resp = resp;
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic loadWord(input int idx, input logic [31:0] data);
    @(posedge clk); #1;
    ldWe   = 1'b1;
    ldAddr = 12'(idx);
    ldData = data;
    @(posedge clk); #1;
    ldWe = 1'b0;
  endtask

  // Returns one step after the clock edge that completed the AR handshake.
  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    @(posedge clk); #1;
    arValid = 1'b1;
    arAddr  = addr;
    arLen   = len;
    arBurst = burst;
    @(negedge clk);
    while (!arReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ar_accept", 64'(arReady), 64'd1);
    @(posedge clk); #1;
    arValid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((sb.size() != 0 || !arReady) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_queue", 64'(sb.size()), 64'd0);
    checkOutput("drain_arready", 64'(arReady), 64'd1);
  endtask

  // Scoreboard plus hold-while-stalled monitor
  logic [34:0] prevBeat = '0;
  logic        prevStall = 1'b0;
  always @(negedge clk) begin
    logic [34:0] curBeat;
    beat_t       e;
    curBeat = {rData, rResp, rLast};
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stall_rvalid", 64'(rValid), 64'd1);
        checkOutput("stall_stable", 64'(curBeat), 64'(prevBeat));
      end
      if (rValid && rReady) begin
        hsCount++;
        if (sb.size() == 0) begin
          checkOutput("unexpected_beat", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          checkOutput("beat_data", 64'(rData), 64'(e.data));
          checkOutput("beat_resp", 64'(rResp), 64'(e.resp));
          checkOutput("beat_last", 64'(rLast), 64'(e.last));
        end
      end
      prevStall = rValid && !rReady;
      prevBeat  = curBeat;
    end
  end

  // RREADY: held high in mode 0, repeating 1,0,0,1 in mode 1
  initial begin
    int phase = 0;
    forever begin
      @(posedge clk); #1;
      if (rrMode == 0) begin
        rReady = 1'b1;
      end else begin
        rReady = ((phase % 4) == 0) || ((phase % 4) == 3);
        phase++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int n;

    vecs[0] = '{32'h14,    8'd0, BURST_INCR,  {32'h00100093, 32'h0, 32'h0, 32'h0},
                {RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY}};
    vecs[1] = '{32'h0,     8'd3, BURST_INCR,  {32'hA0, 32'hA1, 32'hA2, 32'hA3},
                {RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY}};
    vecs[2] = '{32'h3FFC,  8'd1, BURST_INCR,  {32'h0FFF0FFF, 32'h0, 32'h0, 32'h0},
                {RESP_OKAY, RESP_DECERR, RESP_OKAY, RESP_OKAY}};
    vecs[3] = '{32'h8,     8'd2, BURST_WRAP,  {32'h0, 32'h0, 32'h0, 32'h0},
                {RESP_SLVERR, RESP_SLVERR, RESP_SLVERR, RESP_OKAY}};
    vecs[4] = '{32'h4,     8'd2, BURST_FIXED, {32'hA1, 32'hA1, 32'hA1, 32'h0},
                {RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY}};
    vecs[5] = '{32'h7,     8'd0, BURST_INCR,  {32'hA1, 32'h0, 32'h0, 32'h0},
                {RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY}};
    vecs[6] = '{32'h10000, 8'd0, BURST_INCR,  {32'h0, 32'h0, 32'h0, 32'h0},
                {RESP_DECERR, RESP_OKAY, RESP_OKAY, RESP_OKAY}};
    vecs[7] = '{32'h0,     8'd1, 2'b11,       {32'h0, 32'h0, 32'h0, 32'h0},
                {RESP_SLVERR, RESP_SLVERR, RESP_OKAY, RESP_OKAY}};
    vecs[8] = '{32'h8,     8'd1, BURST_INCR,  {32'hA2, 32'hA3, 32'h0, 32'h0},
                {RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY}};

    // Reset state, then the first cycle after release
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_arready", 64'(arReady), 64'd0);
    checkOutput("rst_rvalid", 64'(rValid), 64'd0);
    checkOutput("rst_rlast", 64'(rLast), 64'd0);
    checkOutput("rst_rdata", 64'(rData), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_arready", 64'(arReady), 64'd1);
    checkOutput("idle_rvalid", 64'(rValid), 64'd0);
    checkOutput("idle_rlast", 64'(rLast), 64'd0);

    loadWord(5, 32'h00100093);
    for (int i = 0; i < 4; i++) loadWord(i, 32'hA0 + 32'(i));
    loadWord(4095, 32'h0FFF0FFF);

    // Single read: WAIT cycle, then the beat, then ARREADY back
    expectBeat(32'h00100093, RESP_OKAY, 1'b1);
    applyStimulus(32'h14, 8'd0, BURST_INCR);
    @(negedge clk);
    checkOutput("lat_wait_rvalid", 64'(rValid), 64'd0);
    checkOutput("lat_wait_arready", 64'(arReady), 64'd0);
    @(negedge clk);
    checkOutput("lat_first_rvalid", 64'(rValid), 64'd1);
    @(negedge clk);
    checkOutput("lat_post_arready", 64'(arReady), 64'd1);
    checkOutput("lat_post_rvalid", 64'(rValid), 64'd0);
    waitDrain();

    // Table, first with RREADY high, then with backpressure
    for (int m = 0; m < 2; m++) begin
      rrMode = m;
      for (int i = 0; i < 9; i++) begin
        for (int b = 0; b <= int'(vecs[i].len); b++) begin
          expectBeat(vecs[i].expData[b], vecs[i].expResp[b], b == int'(vecs[i].len));
        end
        applyStimulus(vecs[i].addr, vecs[i].len, vecs[i].burst);
        waitDrain();
      end
    end
    rrMode = 0;
    @(posedge clk); #1;

    // Sustained one beat per cycle with RREADY held
    for (int i = 0; i < 4; i++) expectBeat(32'hA0 + 32'(i), RESP_OKAY, i == 3);
    applyStimulus(32'h0, 8'd3, BURST_INCR);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("stream_rvalid", 64'(rValid), 64'd1);
    end
    waitDrain();

    // Reset in the middle of an eight-beat burst
    for (int i = 4; i < 8; i++) loadWord(i, 32'hB0 + 32'(i));
    for (int i = 0; i < 4; i++) expectBeat(32'hA0 + 32'(i), RESP_OKAY, 1'b0);
    for (int i = 4; i < 8; i++) expectBeat(32'hB0 + 32'(i), RESP_OKAY, i == 7);
    base = hsCount;
    applyStimulus(32'h0, 8'd7, BURST_INCR);
    n = 0;
    while (hsCount < base + 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("mid_beats_seen", 64'(hsCount - base), 64'd3);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_rst_rvalid", 64'(rValid), 64'd0);
    checkOutput("mid_rst_rlast", 64'(rLast), 64'd0);
    checkOutput("mid_rst_arready", 64'(arReady), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    waitDrain();
    expectBeat(32'hB5, RESP_OKAY, 1'b1);
    applyStimulus(32'h14, 8'd0, BURST_INCR);
    waitDrain();
    expectBeat(32'hA2, RESP_OKAY, 1'b0);
    expectBeat(32'hA3, RESP_OKAY, 1'b1);
    applyStimulus(32'h8, 8'd1, BURST_INCR);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
